load_store_unit: RTL

//  Initiator side of the word-wide data memory port: turns core load/store requests into word accesses.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory port bundle for the load/store unit.
interface load_store_unit_if #(
  parameter int XLEN        = 32,
  parameter int DMEM_ADDR_W = 10
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [2:0]             req_funct3;
  logic [XLEN-1:0]        req_addr;
  logic [XLEN-1:0]        req_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [XLEN-1:0]        resp_rdata;
  logic                   resp_err;
  logic [DMEM_ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]        mem_wdata;
  logic                   mem_we;
  logic [XLEN-1:0]        mem_rdata;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: turns core load/store requests into word accesses, sub-word stores via read-modify-write.
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int DMEM_ADDR_W = 10
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t          state_q, state_d;
  logic            write_q, write_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] merged_q, merged_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            legal, aligned;
  logic [4:0]      shift;
  logic [XLEN-1:0] lane, mask, load_val;
  logic            unused_addr;
  assign unused_addr = ^addr_q[XLEN-1:DMEM_ADDR_W+2];
  always_comb begin
    legal    = bus.req_write ? bus.req_funct3 inside {3'b000, 3'b001, 3'b010}
                             : bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    aligned  = bus.req_funct3[1:0] == 2'b01 ? !bus.req_addr[0] :
               bus.req_funct3[1:0] == 2'b10 ? bus.req_addr[1:0] == 2'b00 : 1'b1;
    shift    = {addr_q[1:0], 3'b000};
    lane     = bus.mem_rdata >> shift;
    mask     = (funct3_q[0] ? XLEN'(16'hFFFF) : XLEN'(8'hFF)) << shift;
    load_val = funct3_q == 3'b000 ? {{(XLEN-8){lane[7]}}, lane[7:0]} :
               funct3_q == 3'b001 ? {{(XLEN-16){lane[15]}}, lane[15:0]} :
               funct3_q == 3'b100 ? XLEN'(lane[7:0]) :
               funct3_q == 3'b101 ? XLEN'(lane[15:0]) : lane;
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        write_d  = bus.req_write;
        funct3_d = bus.req_funct3;
        addr_d   = bus.req_addr;
        wdata_d  = bus.req_wdata;
        state_d  = legal && aligned ? ACCESS : RESP;
        // an error response is final at accept time; no memory access follows
        if (!(legal && aligned)) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ACCESS: begin
        rdata_d  = write_q ? '0 : load_val;
        err_d    = 1'b0;
        merged_d = (bus.mem_rdata & ~mask) | ((wdata_q << shift) & mask);
        state_d  = write_q && funct3_q != 3'b010 ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      default: state_d = bus.resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = addr_q[DMEM_ADDR_W+1:2];
  // rst gates the strobe directly so a write in the reset cycle never lands
  assign bus.mem_we     = !rst && (state_q == WRITE || (state_q == ACCESS && write_q && funct3_q == 3'b010));
  assign bus.mem_wdata  = state_q == WRITE ? merged_q : state_q == ACCESS && write_q ? wdata_q : '0;
endmodule
